// File: rtl/led_frame_arbiter.sv
// Two-requester LED frame arbiter: picks one requester per frame
// (round-robin on contention), latches its matrix for the LED driver, kicks
// the driver, and tracks completion, frame rate limiting and driver timeouts.
module led_frame_arbiter #(
    parameter int CLK_FREQ     = 20000000,
    parameter int FRAME_HZ     = 60,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [255:0] frame0,
    input  logic [255:0] frame1,
    output logic [1:0]   grant,
    output logic [255:0] drv_matrix,
    output logic         drv_update,
    input  logic         drv_busy,
    output logic         frame_done,
    output logic [15:0]  frame_count,
    output logic         err
);

    localparam int MIN_PERIOD = CLK_FREQ / FRAME_HZ;
    localparam int PER_W      = (MIN_PERIOD > 1) ? $clog2(MIN_PERIOD) : 1;
    localparam logic [PER_W-1:0] PERIOD_LOAD = PER_W'((MIN_PERIOD > 0) ? MIN_PERIOD - 1 : 0);
    localparam int TO_W       = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        KICK      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic [PER_W-1:0]  period_ctr;
    logic [TO_W-1:0]   to_ctr;
    logic              rr_ptr;
    logic              winner_q;
    logic              winner_d;
    logic [1:0]        grant_d;
    logic              update_d;
    logic              done_d;
    logic              accept;
    logic              timeout;
    logic              to_clr;

    // Reset asserts asynchronously but releases two edges later, so no flop
    // sees reset removal close to an active clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // FSM state register.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output decode; req is only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        grant_d  = 2'b00;
        update_d = 1'b0;
        done_d   = 1'b0;
        accept   = 1'b0;
        timeout  = 1'b0;
        to_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 2'b00 && period_ctr == '0 && !drv_busy) begin
                    accept   = 1'b1;
                    state_d  = KICK;
                    winner_d = (req == 2'b11) ? rr_ptr : req[1];
                    grant_d  = winner_d ? 2'b10 : 2'b01;
                end
            end
            KICK: begin
                update_d = 1'b1;
                to_clr   = 1'b1;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (drv_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_ctr == TO_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!drv_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame-rate limiter: loaded as KICK is entered so successive driver
    // updates are exactly MIN_PERIOD cycles apart; free-runs down to zero.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            period_ctr <= '0;
        end else if (accept) begin
            period_ctr <= PERIOD_LOAD;
        end else if (period_ctr != '0) begin
            period_ctr <= period_ctr - PER_W'(1);
        end
    end

    // Counts cycles spent waiting for the driver to report busy.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            to_ctr <= '0;
        end else if (to_clr) begin
            to_ctr <= '0;
        end else if (state_q == WAIT_BUSY) begin
            to_ctr <= to_ctr + TO_W'(1);
        end
    end

    // Registered outputs, matrix latch and round-robin bookkeeping.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            grant       <= 2'b00;
            drv_update  <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
            err         <= 1'b0;
            drv_matrix  <= '0;
            winner_q    <= 1'b0;
            rr_ptr      <= 1'b0;
        end else begin
            grant      <= grant_d;
            drv_update <= update_d;
            frame_done <= done_d;
            if (accept) begin
                drv_matrix <= winner_d ? frame1 : frame0;
                winner_q   <= winner_d;
            end
            if (done_d) begin
                frame_count <= frame_count + 16'd1;
                rr_ptr      <= ~winner_q;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Scoreboard bench for led_frame_arbiter: stimulus queues expected grant and
// frame_done events, a negedge monitor pops and compares them as they appear.
module tb_led_frame_arbiter;

    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int E_UPD   = 1;
    localparam int E_DONE  = 2;
    localparam int E_GRANT = 3;
    localparam logic [255:0] ONES = {256{1'b1}};
    localparam logic [255:0] P0   = {8{32'hDEADBEEF}};
    localparam logic [255:0] P1   = {8{32'h01234567}};
    localparam logic [255:0] P2   = {8{32'h5A5AC3C3}};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   req = 2'b00;
    logic [255:0] frame0 = '0;
    logic [255:0] frame1 = '0;
    logic         drv_busy = 1'b0;
    logic [1:0]   grant;
    logic [255:0] drv_matrix;
    logic         drv_update;
    logic         frame_done;
    logic [15:0]  frame_count;
    logic         err;

    typedef struct {
        int           kind;
        logic [1:0]   g;
        logic [255:0] m;
        logic [15:0]  fc;
    } exp_t;

    exp_t exp_q[$];
    int   upd_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_grant = 0;
    int   n_upd = 0;
    int   n_done = 0;
    int   upd_last = 0;
    int   err_cyc = -1;
    logic err_prev = 1'b0;
    bit   busy_en = 1'b1;
    int   busy_left = 0;

    led_frame_arbiter #(
        .CLK_FREQ    (6000),
        .FRAME_HZ    (60),
        .BUSY_TIMEOUT(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .frame0     (frame0),
        .frame1     (frame1),
        .grant      (grant),
        .drv_matrix (drv_matrix),
        .drv_update (drv_update),
        .drv_busy   (drv_busy),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .err        (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, want);
        end
    endtask

    // Driver model: busy rises one cycle after update and stays for 20 cycles.
    always @(negedge clock) begin
        if (!reset) begin
            drv_busy  = 1'b0;
            busy_left = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) drv_busy = 1'b0;
        end else if (drv_update && busy_en) begin
            drv_busy  = 1'b1;
            busy_left = 20;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clock) begin
        exp_t e;
        if (grant != 2'b00) begin
            n_grant++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant actual=%0h required=none", grant);
            end else begin
                e = exp_q.pop_front();
                check("sb_kind_at_grant", K_GRANT, e.kind);
                check("sb_grant", grant, e.g);
                check("sb_matrix", drv_matrix, e.m);
            end
        end
        if (frame_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("sb_kind_at_done", K_DONE, e.kind);
                check("sb_frame_count", frame_count, e.fc);
            end
        end
        if (drv_update) begin
            n_upd++;
            upd_last = cyc;
            upd_q.push_back(cyc);
        end
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
    end

    function automatic int evt_cnt(input int kind);
        case (kind)
            E_UPD:   return n_upd;
            E_DONE:  return n_done;
            default: return n_grant;
        endcase
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_grant(input logic [1:0] g, input logic [255:0] m);
        exp_t e;
        e.kind = K_GRANT; e.g = g; e.m = m; e.fc = 16'd0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [15:0] fc);
        exp_t e;
        e.kind = K_DONE; e.g = 2'b00; e.m = '0; e.fc = fc;
        exp_q.push_back(e);
    endtask

    task automatic wait_next(input int kind, input int budget, input string nm);
        int base;
        int n;
        base = evt_cnt(kind);
        n = 0;
        while (evt_cnt(kind) == base && n < budget) begin
            tick();
            n++;
        end
        check(nm, (evt_cnt(kind) > base) ? 1 : 0, 1);
    endtask

    task automatic reset_and_check(input string pfx);
        reset = 1'b0;
        #1;
        check({pfx, "_grant"}, grant, 0);
        check({pfx, "_drv_update"}, drv_update, 0);
        check({pfx, "_drv_matrix"}, drv_matrix, 0);
        check({pfx, "_frame_done"}, frame_done, 0);
        check({pfx, "_frame_count"}, frame_count, 0);
        check({pfx, "_err"}, err, 0);
    endtask

    task automatic release_reset();
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int b;
        int n;
        int base_done;

        #2;
        reset_and_check("rst_init");
        release_reset();

        // Single requester, latency and matrix load.
        frame0 = ONES;
        frame1 = P1;
        push_grant(2'b01, ONES);
        push_done(16'd1);
        t0 = cyc;
        req = 2'b01;
        wait_next(E_UPD, 10, "a_wait_update");
        check("a_update_latency", upd_last - t0, 2);
        check("a_matrix", drv_matrix, ONES);
        req = 2'b00;
        wait_next(E_DONE, 60, "a_wait_done");
        check("a_frame_count", frame_count, 1);
        repeat (3) tick();
        check("a_sb_drained", exp_q.size(), 0);

        // Contention: alternating grants, rate-limited updates.
        reset_and_check("rst_b");
        release_reset();
        frame0 = P0;
        frame1 = P1;
        push_grant(2'b01, P0); push_done(16'd1);
        push_grant(2'b10, P1); push_done(16'd2);
        push_grant(2'b01, P0); push_done(16'd3);
        b = upd_q.size();
        req = 2'b11;
        wait_next(E_UPD, 10, "b_wait_update1");
        wait_next(E_UPD, 150, "b_wait_update2");
        wait_next(E_UPD, 150, "b_wait_update3");
        req = 2'b00;
        wait_next(E_DONE, 60, "b_wait_done3");
        if (upd_q.size() >= b + 3) begin
            check("b_spacing_1", upd_q[b+1] - upd_q[b], 100);
            check("b_spacing_2", upd_q[b+2] - upd_q[b+1], 100);
        end
        check("b_frame_count", frame_count, 3);
        check("b_sb_drained", exp_q.size(), 0);

        // Driver never goes busy: timeout, sticky err, same winner next.
        reset_and_check("rst_c");
        release_reset();
        busy_en = 1'b0;
        push_grant(2'b01, P0);
        b = upd_q.size();
        req = 2'b11;
        wait_next(E_UPD, 10, "c_wait_update");
        n = 0;
        while (!err && n < 20) begin
            tick();
            n++;
        end
        check("c_err_set", err, 1);
        if (upd_q.size() > b) check("c_err_delay", err_cyc - upd_q[b], 8);
        check("c_frame_count_held", frame_count, 0);
        busy_en = 1'b1;
        push_grant(2'b01, P0);
        push_done(16'd1);
        wait_next(E_UPD, 150, "c_wait_update2");
        req = 2'b00;
        wait_next(E_DONE, 60, "c_wait_done");
        check("c_err_sticky", err, 1);
        check("c_frame_count", frame_count, 1);
        check("c_sb_drained", exp_q.size(), 0);

        // Frame counter wrap from 0xFFFF.
        reset_and_check("rst_d");
        release_reset();
        force dut.frame_count = 16'hFFFF;
        tick();
        tick();
        release dut.frame_count;
        tick();
        check("d_preload", frame_count, 16'hFFFF);
        push_grant(2'b01, P0);
        push_done(16'h0000);
        req = 2'b01;
        wait_next(E_UPD, 10, "d_wait_update");
        req = 2'b00;
        wait_next(E_DONE, 60, "d_wait_done");
        check("d_wrap", frame_count, 16'h0000);
        check("d_sb_drained", exp_q.size(), 0);

        // Reset in WAIT_DONE aborts the frame; fast restart afterwards.
        reset_and_check("rst_e");
        release_reset();
        push_grant(2'b01, P0);
        push_done(16'd1);
        req = 2'b01;
        wait_next(E_UPD, 10, "e_wait_update1");
        req = 2'b00;
        wait_next(E_DONE, 60, "e_wait_done1");
        push_grant(2'b01, P0);
        req = 2'b01;
        wait_next(E_UPD, 150, "e_wait_update2");
        req = 2'b00;
        repeat (4) tick();
        check("e_busy_before_reset", drv_busy, 1);
        base_done = n_done;
        reset_and_check("rst_mid");
        repeat (30) tick();
        check("e_no_done_in_reset", n_done, base_done);
        reset = 1'b1;
        repeat (3) tick();
        check("e_no_done_after_release", n_done, base_done);
        push_grant(2'b10, P1);
        push_done(16'd1);
        req = 2'b10;
        n = 0;
        while (grant == 2'b00 && n < 4) begin
            tick();
            n++;
        end
        check("e_regrant_within_2", (n <= 2) ? 1 : 0, 1);
        req = 2'b00;
        wait_next(E_DONE, 60, "e_wait_done2");
        check("e_sb_drained", exp_q.size(), 0);

        // Matrix holds while the source frame changes mid-refresh.
        reset_and_check("rst_f");
        release_reset();
        frame0 = P0;
        push_grant(2'b01, P0);
        push_done(16'd1);
        req = 2'b01;
        wait_next(E_UPD, 10, "f_wait_update1");
        repeat (4) tick();
        req = 2'b00;
        frame0 = P2;
        repeat (3) tick();
        check("f_hold_wait_done", drv_matrix, P0);
        wait_next(E_DONE, 60, "f_wait_done1");
        check("f_hold_idle", drv_matrix, P0);
        push_grant(2'b01, P2);
        push_done(16'd2);
        req = 2'b01;
        wait_next(E_UPD, 150, "f_wait_update2");
        req = 2'b00;
        check("f_new_matrix", drv_matrix, P2);
        wait_next(E_DONE, 60, "f_wait_done2");
        check("f_sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_frame_arbiter.md
LED_FRAME_ARBITER -- requirements
Module: led_frame_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 20000000, meaning system clock in Hz.
REQ-002 The block SHALL have parameter FRAME_HZ, default 60, meaning max frame rate; MIN_PERIOD = CLK_FREQ/FRAME_HZ cycles (integer).
REQ-003 The block SHALL have parameter BUSY_TIMEOUT, default 8, meaning max cycles from drv_update to drv_busy high.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; ports: clock (input, 1) and reset (input, 1).
REQ-005 The block SHALL have port req (input, 2), meaning per-requester frame request level.
REQ-006 The block SHALL have ports frame0 and frame1 (input, 256 each), meaning requester matrices.
REQ-007 The block SHALL have port grant (output, 2), meaning one-hot one-cycle frame acceptance pulse.
REQ-008 The block SHALL have port drv_matrix (output, 256), meaning latched matrix to the LED driver.
REQ-009 The block SHALL have port drv_update (output, 1), meaning one-cycle start pulse to the driver.
REQ-010 The block SHALL have port drv_busy (input, 1), meaning driver refresh in progress.
REQ-011 The block SHALL have ports frame_done (output, 1, one-cycle pulse), frame_count (output, 16), and err (output, 1, sticky timeout flag).

Function
REQ-012 All outputs SHALL be registered.
REQ-013 The FSM SHALL have states IDLE, KICK, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE->KICK SHALL occur when req!=0, period_ctr==0 and drv_busy==0; otherwise IDLE SHALL hold.
REQ-015 On IDLE->KICK the winner SHALL be selected round-robin: a single requester wins; if both request, the requester indexed by rr_ptr wins.
REQ-016 On IDLE->KICK, grant[winner] SHALL pulse for exactly one cycle and drv_matrix SHALL load frame[winner] in the same edge.
REQ-017 drv_matrix SHALL hold its value at all times except the IDLE->KICK edge.
REQ-018 In KICK, drv_update SHALL be 1 for exactly one cycle; period_ctr SHALL load MIN_PERIOD-1; the FSM SHALL go to WAIT_BUSY; latency req-to-drv_update SHALL be 2 cycles when eligible.
REQ-019 period_ctr SHALL decrement every cycle it is nonzero, saturate at 0, and run in all states.
REQ-020 In WAIT_BUSY, drv_busy==1 SHALL move the FSM to WAIT_DONE.
REQ-021 In WAIT_BUSY, BUSY_TIMEOUT cycles without drv_busy SHALL set err=1 and return to IDLE with no frame_done, no frame_count increment, and rr_ptr unchanged.
REQ-022 In WAIT_DONE, drv_busy==0 SHALL pulse frame_done for one cycle, increment frame_count modulo 2^16 (0xFFFF->0x0000), set rr_ptr to the non-winner index, and return to IDLE.
REQ-023 Requests arriving or dropping outside IDLE SHALL be ignored; req is re-sampled only in IDLE.
REQ-024 A req deasserting in the same cycle as the IDLE evaluation SHALL not win.
REQ-025 err SHALL clear only on reset.

Reset
REQ-026 While reset==0, the block SHALL asynchronously force: state=IDLE, grant=0, drv_update=0, drv_matrix=0, frame_done=0, frame_count=0, err=0, rr_ptr=0, period_ctr=0.
REQ-027 Reset asserted mid-frame SHALL abort with no frame_done pulse; after release, the block SHALL accept a request on the first eligible cycle.
REQ-028 Reset release SHALL be synchronised internally so that the first active edge is clean.

Verification (bench: CLK_FREQ=6000, FRAME_HZ=60 -> MIN_PERIOD=100, BUSY_TIMEOUT=8; driver model asserts busy 1 cycle after update and holds it 20 cycles)
REQ-029 The bench SHALL check: req=01, frame0=all-ones -> grant=01 one cycle, drv_matrix=all-ones, drv_update two cycles after req, frame_done after busy falls, frame_count=1.
REQ-030 The bench SHALL check: req=11 held -> grants alternate 01,10,01; drv_update pulses spaced exactly 100 cycles apart; frame_count=3.
REQ-031 The bench SHALL check: driver model never asserts busy -> err=1 exactly 8 cycles after KICK, frame_count unchanged, and the next grant goes to the same requester.
REQ-032 The bench SHALL check: frame_count preloaded to 0xFFFF via 65535 frames (or forced) and one more frame -> frame_count=0x0000 and frame_done pulses.
REQ-033 The bench SHALL check: reset=0 during WAIT_DONE -> all outputs zero immediately, no frame_done; after release, req=10 -> grant=10 within 2 cycles.
REQ-034 The bench SHALL check: frame0 changed during WAIT_DONE -> drv_matrix unchanged until the next grant.
